// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer (master) and the bus-based datapath (slave).
// The master modport is the sequencer view: datapath status in, control strobes out.
interface control_sequencer_if;
  // Datapath status seen by the sequencer
  logic        run;
  logic [31:0] ir;
  logic        con;
  logic        mem_ready;

  // Bus-drive enables, at most one high per cycle
  logic pc_out;
  logic mdr_out;
  logic zlo_out;
  logic c_out;
  logic r_out;
  logic ba_out;

  // Register load enables
  logic pc_in;
  logic mar_in;
  logic mdr_in;
  logic ir_in;
  logic y_in;
  logic z_in;
  logic r_in;
  logic con_in;

  // Register select, ALU and memory controls, status
  logic gra;
  logic grb;
  logic inc_pc;
  logic add;
  logic read;
  logic write;
  logic running;
  logic illegal;
  logic fault;

  modport master (
    input  run, ir, con, mem_ready,
    output pc_out, mdr_out, zlo_out, c_out, r_out, ba_out,
    output pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in, con_in,
    output gra, grb, inc_pc, add, read, write, running, illegal, fault
  );

  modport slave (
    output run, ir, con, mem_ready,
    input  pc_out, mdr_out, zlo_out, c_out, r_out, ba_out,
    input  pc_in, mar_in, mdr_in, ir_in, y_in, z_in, r_in, con_in,
    input  gra, grb, inc_pc, add, read, write, running, illegal, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0..T2), decode IR[31:27] in T3, then per-instruction steps.
// Memory steps hold Read/Write until mem_ready. Optional watchdog: define CTRL_WATCHDOG_EN to
// turn a long memory stall into a sticky FAULT state (cleared only by clear).
module control_sequencer (
  input  logic                clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpBr   = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [4:0] {
    StIdle, StT0, StT1, StT1m, StT2, StT3,
    StLdT4, StLdT5, StLdT6, StLdT7,
    StStT4, StStT5, StStT6, StStT7,
    StAluT4, StAluT5,
    StBrT4, StBrT5, StBrT6,
    StHalted, StFault
  } state_e;

  state_e     state_q, state_d;
  state_e     next_instr;
  logic       in_wait;
  logic [4:0] opcode;

  assign opcode     = bus.ir[31:27];
  assign next_instr = bus.run ? StT0 : StIdle;

`ifdef CTRL_WATCHDOG_EN
  localparam logic [3:0] WaitLimit = 4'd15;
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  // Next-state selection; memory steps only advance when mem_ready is high
  always_comb begin
    state_d = state_q;
    in_wait = 1'b0;
    case (state_q)
      StIdle:  if (bus.run) state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT1m;
      StT1m: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_d = StT2;
      end
      StT2:    state_d = StT3;
      StT3: begin
        case (opcode)
          OpLd:          state_d = StLdT4;
          OpLdi, OpAddi: state_d = StAluT4;
          OpSt:          state_d = StStT4;
          OpBr:          state_d = StBrT4;
          OpHalt:        state_d = StHalted;
          default:       state_d = next_instr;  // nop and unknown opcodes
        endcase
      end
      StLdT4:  state_d = StLdT5;
      StLdT5:  state_d = StLdT6;
      StLdT6: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_d = StLdT7;
      end
      StLdT7:  state_d = next_instr;
      StStT4:  state_d = StStT5;
      StStT5:  state_d = StStT6;
      StStT6:  state_d = StStT7;
      StStT7: begin
        in_wait = 1'b1;
        if (bus.mem_ready) state_d = next_instr;
      end
      StAluT4: state_d = StAluT5;
      StAluT5: state_d = next_instr;
      StBrT4:  state_d = StBrT5;
      StBrT5:  state_d = StBrT6;
      StBrT6:  state_d = next_instr;
      StHalted, StFault: state_d = state_q;
      default: state_d = StIdle;
    endcase

`ifdef CTRL_WATCHDOG_EN
    // Count stalled cycles in a wait step; any non-stalled cycle restarts the count
    wait_cnt_d = '0;
    if (in_wait && !bus.mem_ready) begin
      if (wait_cnt_q == WaitLimit - 4'd1) begin
        state_d = StFault;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
`endif
  end

  // State register with synchronous active-low clear
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= StIdle;
`ifdef CTRL_WATCHDOG_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CTRL_WATCHDOG_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // Strobe decode from the current step (and IR, which is stable from T3 on)
  always_comb begin
    bus.pc_out  = 1'b0;
    bus.mdr_out = 1'b0;
    bus.zlo_out = 1'b0;
    bus.c_out   = 1'b0;
    bus.r_out   = 1'b0;
    bus.ba_out  = 1'b0;
    bus.pc_in   = 1'b0;
    bus.mar_in  = 1'b0;
    bus.mdr_in  = 1'b0;
    bus.ir_in   = 1'b0;
    bus.y_in    = 1'b0;
    bus.z_in    = 1'b0;
    bus.r_in    = 1'b0;
    bus.con_in  = 1'b0;
    bus.gra     = 1'b0;
    bus.grb     = 1'b0;
    bus.inc_pc  = 1'b0;
    bus.add     = 1'b0;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.illegal = 1'b0;
    bus.running = !(state_q inside {StIdle, StHalted, StFault});
`ifdef CTRL_WATCHDOG_EN
    bus.fault   = (state_q == StFault);
`else
    bus.fault   = 1'b0;
`endif
    case (state_q)
      StT0: begin
        bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; bus.z_in = 1'b1;
      end
      StT1:  begin bus.zlo_out = 1'b1; bus.pc_in = 1'b1; end
      StT1m: begin bus.read = 1'b1; bus.mdr_in = 1'b1; end
      StT2:  begin bus.mdr_out = 1'b1; bus.ir_in = 1'b1; end
      StT3: begin
        case (opcode)
          OpLd, OpLdi, OpSt: begin bus.grb = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1; end
          OpAddi:            begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1; end
          OpBr:              begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.con_in = 1'b1; end
          OpNop, OpHalt:     ;
          default:           bus.illegal = 1'b1;
        endcase
      end
      StLdT4, StStT4, StAluT4, StBrT5: begin
        bus.c_out = 1'b1; bus.add = 1'b1; bus.z_in = 1'b1;
      end
      StLdT5, StStT5: begin bus.zlo_out = 1'b1; bus.mar_in = 1'b1; end
      StLdT6:  begin bus.read = 1'b1; bus.mdr_in = 1'b1; end
      StLdT7:  begin bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
      StStT6:  begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.mdr_in = 1'b1; end
      StStT7:  bus.write = 1'b1;
      StAluT5: begin bus.zlo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
      StBrT4:  begin bus.pc_out = 1'b1; bus.y_in = 1'b1; end
      // Branch taken only when the condition flop is set
      StBrT6:  begin bus.zlo_out = 1'b1; bus.pc_in = bus.con; end
      default: ;
    endcase
  end

endmodule
